// File: rtl/parallel_dff_bank_if.sv
// Bus bundle for parallel_dff_bank: control and data in, stored state out.
// The bank drives the slave side and the user of the bank drives the master side.
interface parallel_dff_bank_if #(
    parameter int WAY  = 3,
    parameter int WIRE = 8
);
    logic [1:0]          mode;
    logic [WAY-1:0]      en;
    logic [WAY*WIRE-1:0] D;
    logic [WIRE-1:0]     sin;
    logic                sin_vld;
    logic [WAY*WIRE-1:0] Q;
    logic [WAY*WIRE-1:0] QN;
    logic [WAY-1:0]      valid;
    logic [WIRE-1:0]     sout;
    logic                sout_vld;
    logic [WAY-1:0]      perr;

    modport master (
        output mode, en, D, sin, sin_vld,
        input  Q, QN, valid, sout, sout_vld, perr
    );

    modport slave (
        input  mode, en, D, sin, sin_vld,
        output Q, QN, valid, sout, sout_vld, perr
    );
endinterface

// File: rtl/parallel_dff_bank.sv
// WAY x WIRE register bank with per-way load/clear, a shift-chain mode and valid flags.
// Optional per-way even parity is enabled with `define PARALLEL_DFF_BANK_PARITY_EN.
module parallel_dff_bank #(
    parameter int WAY  = 3,
    parameter int WIRE = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    parallel_dff_bank_if.slave bus
);
    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_SHIFT = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    logic [WAY*WIRE-1:0] data_q, data_d;
    logic [WAY-1:0]      valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        case (bus.mode)
            MODE_LOAD: begin
                for (int k = 0; k < WAY; k++) begin
                    if (bus.en[k]) begin
                        data_d[k*WIRE +: WIRE] = bus.D[k*WIRE +: WIRE];
                        valid_d[k]             = 1'b1;
                    end
                end
            end
            MODE_SHIFT: begin
                data_d[WIRE-1:0] = bus.sin;
                valid_d[0]       = bus.sin_vld;
                for (int k = 1; k < WAY; k++) begin
                    data_d[k*WIRE +: WIRE] = data_q[(k-1)*WIRE +: WIRE];
                    valid_d[k]             = valid_q[k-1];
                end
            end
            MODE_CLEAR: begin
                for (int k = 0; k < WAY; k++) begin
                    if (bus.en[k]) begin
                        data_d[k*WIRE +: WIRE] = '0;
                        valid_d[k]             = 1'b0;
                    end
                end
            end
            MODE_HOLD: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef PARALLEL_DFF_BANK_PARITY_EN
    logic [WAY-1:0] par_q, par_d;
    logic [WAY-1:0] perr_w;

    // Parity is taken from the value written, never re-derived from stored data,
    // so a corrupted stored bit stays visible until the way is rewritten.
    always_comb begin
        par_d = par_q;
        case (bus.mode)
            MODE_LOAD: begin
                for (int k = 0; k < WAY; k++) begin
                    if (bus.en[k]) par_d[k] = ^bus.D[k*WIRE +: WIRE];
                end
            end
            MODE_SHIFT: begin
                par_d[0] = ^bus.sin;
                for (int k = 1; k < WAY; k++) par_d[k] = par_q[k-1];
            end
            MODE_CLEAR: begin
                for (int k = 0; k < WAY; k++) begin
                    if (bus.en[k]) par_d[k] = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) par_q <= '0;
        else        par_q <= par_d;
    end

    always_comb begin
        perr_w = '0;
        for (int k = 0; k < WAY; k++) begin
            perr_w[k] = valid_q[k] & (par_q[k] ^ (^data_q[k*WIRE +: WIRE]));
        end
    end

    assign bus.perr = perr_w;
`else
    assign bus.perr = '0;
`endif

    assign bus.Q        = data_q;
    assign bus.QN       = ~data_q;
    assign bus.valid    = valid_q;
    assign bus.sout     = data_q[(WAY-1)*WIRE +: WIRE];
    assign bus.sout_vld = valid_q[WAY-1];
endmodule

// File: doc/parallel_dff_bank.md
Name: parallel_dff_bank

Overview:
- Edge-triggered successor to the parallel latch bank: WAY independent WIRE-bit registers, each with its own write enable and a valid flag.
- Adds a mode-selected shift-chain path so the bank also acts as a WAY-deep delay line or pipeline.
- Also adds a selective-clear path.
- Sits in the memory library as the generic multi-channel storage primitive for register files, pipeline stages and capture buffers.

Parameters:
- WAY, 3, number of channels (register slots); legal range >= 1.
- WIRE, 8, bits per channel; legal range >= 1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- mode  input  2  operation select: 00 HOLD, 01 LOAD, 10 SHIFT, 11 CLEAR.
- en  input  WAY  per-way enable; bit k governs way k in LOAD and CLEAR; ignored in HOLD and SHIFT.
- D  input  WAY*WIRE  parallel data; way k occupies D[k*WIRE +: WIRE].
- sin  input  WIRE  shift-chain input into way 0.
- sin_vld  input  1  valid bit accompanying sin.
- Q  output  WAY*WIRE  stored data, same packing as D.
- QN  output  WAY*WIRE  bitwise complement of Q at all times.
- valid  output  WAY  per-way valid flag.
- sout  output  WIRE  equals Q of way WAY-1 (combinational from state).
- sout_vld  output  1  equals valid[WAY-1].
- perr  output  WAY  per-way parity error; see Optional Feature.

Behaviour:
- Reset, sampled only at the rising edge of clk while rst_n=0:
  - Q=0, QN=all ones, valid=0, perr=0.
  - Reset takes priority over every mode.
  - Asserting reset mid-shift discards all contents in that same edge.
- All register updates take effect one cycle after the inputs are sampled. Outputs are registered values, or pure functions of registered state.
- HOLD (00): all ways and valid flags retain their values.
- LOAD (01), for each way k:
  - en[k]=1: way k <- D slice k, and valid[k] <- 1.
  - en[k]=0: way k and valid[k] hold.
  - en=0 entirely is equivalent to HOLD.
- SHIFT (10), all ways move together; en is ignored:
  - Way 0 <- sin and valid[0] <- sin_vld.
  - Way k <- way k-1 and valid[k] <- valid[k-1], for k = 1..WAY-1.
  - The old contents of way WAY-1 are presented on sout/sout_vld during the shift cycle and are lost after the edge.
  - WAY=1: way 0 <- sin and sout shows the old way 0.
- CLEAR (11), for each way k:
  - en[k]=1: way k <- 0 and valid[k] <- 0.
  - en[k]=0: way k holds.
- Data is stored regardless of valid. valid is informational only and never gates Q.
- QN is the complement of Q, never independently stored; QN == ~Q is an invariant at every cycle.
- Parameter degeneracies:
  - WIRE=1 works with single-bit slices.
  - There are no X-propagating paths; every mode encoding is defined.

Optional Feature:
- Macro: PARALLEL_DFF_BANK_PARITY_EN.
- With the macro defined:
  - Each way stores one extra even-parity bit, computed from the written value on every LOAD, SHIFT or CLEAR write. CLEAR stores parity 0.
  - perr[k] = valid[k] AND (stored parity XOR reduction-XOR of way k).
  - perr is combinational from state and resets to 0.
  - A force/hierarchical corruption of a data bit in a valid way raises perr[k] on the following evaluation.
  - Parity travels with data in SHIFT.
- Without the macro: no parity storage; perr is tied to 0. The port list is unchanged.

Test Plan (WAY=3, WIRE=8):
- Reset: hold rst_n=0 for 2 edges with mode=01, en=111, D=0xAABBCC -> Q=0x000000, QN=0xFFFFFF, valid=000; release -> next LOAD edge gives Q=0xAABBCC, valid=111.
- Selective load: from reset, mode=01, en=010, D=0x112233 -> Q=0x002200, valid=010, QN=0xFFDDFF; then mode=00 for 3 cycles -> all outputs unchanged.
- Shift pipeline: from reset, mode=10 with sin=0x01,0x02,0x03 and sin_vld=1,0,1 on successive edges -> Q=0x010203 and valid=101. The fourth shift (sin=0x04, sin_vld=1) shows sout=0x01 and sout_vld=1 before the edge, then Q=0x020304 and valid=011.
- Clear and reset priority: Q=0xAABBCC with valid=111, mode=11, en=101 -> Q=0x00BB00, valid=010. Then rst_n=0 with mode=01, en=111 -> Q=0, valid=0 (reset wins).
- WAY=1, WIRE=1 instance: LOAD D=1 -> Q=1, QN=0; SHIFT sin=0 -> sout=1 during the cycle, then Q=0.
- Parity, macro defined: LOAD 0x5A into way 1, then force one bit of way 1 -> perr=010; CLEAR en=010 -> perr=000. Macro undefined: the same stimulus keeps perr=000.
